// File: rtl/treeval_param.sv
// treeval_param: loadable decision-tree evaluator; back-propagates weighted leaf rewards to the root,
// taking the best action at each decision node, and reports the root's expected reward and action.
module treeval_param #(
    parameter int MAX_NODES   = 1024,
    parameter int MAX_ACTIONS = 8,
    parameter int W_ADDR      = $clog2(MAX_NODES),
    parameter int W_ACTION    = $clog2(MAX_ACTIONS),
    parameter int W_REWARD    = 12,
    parameter int W_WEIGHT    = 8,
    parameter int NORM_SHIFT  = 7,
    parameter int W_ACC       = W_REWARD + W_WEIGHT + W_ADDR,
    parameter int W_DATA      = (W_REWARD > W_ADDR) ? ((W_REWARD > W_WEIGHT) ? W_REWARD : W_WEIGHT)
                                                    : ((W_ADDR > W_WEIGHT) ? W_ADDR : W_WEIGHT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ld_valid,
    input  logic [1:0]                 ld_field,
    input  logic [W_ADDR-1:0]          ld_addr,
    input  logic [W_DATA-1:0]          ld_data,
    input  logic                       cfg_valid,
    input  logic [W_ADDR:0]            cfg_nodes,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic signed [W_REWARD-1:0] exp,
    output logic [W_ACTION-1:0]        act
);
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, COMMIT, DONE} state_t;

    localparam logic signed [W_REWARD-1:0] R_MAX = {1'b0, {(W_REWARD-1){1'b1}}};
    localparam logic signed [W_REWARD-1:0] R_MIN = {1'b1, {(W_REWARD-1){1'b0}}};

    state_t state, state_nx;

    logic [W_WEIGHT-1:0]        weight_mem [MAX_NODES];
    logic [W_ADDR-1:0]          parent_mem [MAX_NODES];
    logic signed [W_REWARD-1:0] reward_mem [MAX_NODES];
    logic [W_ACTION-1:0]        action_mem [MAX_NODES];

    logic [W_ADDR:0]            n, n_eff;
    logic [W_ADDR-1:0]          cur, grp_parent;
    logic signed [W_ACC-1:0]    acc [MAX_ACTIONS];
    logic [MAX_ACTIONS-1:0]     vld;
    logic signed [W_ACC-1:0]    rw_ext, wt_ext, prod, best, shifted;
    logic [W_ACTION-1:0]        best_act;
    logic signed [W_REWARD-1:0] sat_val;
    logic                       found, ld_en, grp_end;

    assign ld_en   = ld_valid && state == IDLE;
    assign n_eff   = (cfg_valid && state == IDLE) ? cfg_nodes : n;
    // Lookahead on the next node's parent closes the sibling group without a bubble
    assign grp_end = cur == W_ADDR'(1) || parent_mem[cur - 1'b1] != grp_parent;
    assign rw_ext  = W_ACC'(reward_mem[cur]);
    assign wt_ext  = W_ACC'({1'b0, weight_mem[cur]});
    assign prod    = rw_ext * wt_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = !start ? IDLE : (n_eff < (W_ADDR+1)'(2)) ? DONE : CLEAR;
            CLEAR:   state_nx = ACCUM;
            ACCUM:   state_nx = grp_end ? COMMIT : ACCUM;
            COMMIT:  state_nx = (cur == '0) ? DONE : CLEAR;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state == CLEAR || state == ACCUM || state == COMMIT;
        done = state == DONE;
    end

    // Strict compare keeps the lowest action index on ties; empty slots never compete
    always_comb begin
        found    = 1'b0;
        best     = '0;
        best_act = '0;
        for (int i = 0; i < MAX_ACTIONS; i++) begin
            if (vld[i] && (!found || acc[i] > best)) begin
                found    = 1'b1;
                best     = acc[i];
                best_act = W_ACTION'(i);
            end
        end
        shifted = best >>> NORM_SHIFT;
        sat_val = shifted > W_ACC'(R_MAX) ? R_MAX : shifted < W_ACC'(R_MIN) ? R_MIN : W_REWARD'(shifted);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n          <= '0;
            cur        <= '0;
            grp_parent <= '0;
            vld        <= '0;
            exp        <= '0;
            act        <= '0;
            for (int i = 0; i < MAX_ACTIONS; i++)
                acc[i] <= '0;
        end else begin
            if (state == IDLE && cfg_valid)
                n <= cfg_nodes;
            if (state == IDLE && start)
                cur <= W_ADDR'(n_eff - 1'b1);
            if (state == CLEAR) begin
                vld        <= '0;
                grp_parent <= parent_mem[cur];
                for (int i = 0; i < MAX_ACTIONS; i++)
                    acc[i] <= '0;
            end
            if (state == ACCUM) begin
                acc[action_mem[cur]] <= acc[action_mem[cur]] + prod;
                vld[action_mem[cur]] <= 1'b1;
                cur                  <= cur - 1'b1;
            end
            if (state == DONE) begin
                exp <= reward_mem[0];
                act <= action_mem[0];
            end
        end
    end

    // Node memory keeps its contents across reset
    always_ff @(posedge clk) begin
        if (ld_en && ld_field == 2'd0)
            weight_mem[ld_addr] <= ld_data[W_WEIGHT-1:0];
        if (ld_en && ld_field == 2'd1)
            parent_mem[ld_addr] <= ld_data[W_ADDR-1:0];
        if (ld_en && ld_field == 2'd2)
            reward_mem[ld_addr] <= ld_data[W_REWARD-1:0];
        if (ld_en && ld_field == 2'd3)
            action_mem[ld_addr] <= ld_data[W_ACTION-1:0];
        if (state == COMMIT) begin
            reward_mem[grp_parent] <= sat_val;
            if (grp_parent == '0)
                action_mem[0] <= best_act;
        end
    end
endmodule
